laser_bank: RTL and testbench

Multi-shot laser controller for the player gun: up to NUM_SHOTS independent laser slots, each allocated on a fire press, moving upward once per motion tick and freed on kill or at the top of the screen. It also renders all active shots into a single registered 3-bit pixel colour for the VGA mixer. It sits between the gun/ship block, the alien collision logic (per-slot kill inputs) and the colour priority mixer.

---
 rtl/laser_pkg.sv | 23 ++
 rtl/laser_hit_test.sv | 51 +++++
 rtl/laser_bank.sv | 140 ++++++++++++++
 tb/tb_laser_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and constants for the multi-shot laser bank.
package laser_pkg;

  // Screen coordinate (x or y), 10 bits covers 640x480.
  typedef logic [9:0] coord_t;

  // Shape selector; encoding 3 is not listed and renders as a circle.
  typedef enum logic [1:0] {
    CIRCLE = 2'd0,
    SQUARE = 2'd1,
    BAR    = 2'd2
  } shapeMode_t;

  localparam logic [2:0] LASER_COLOR_DEF = 3'd6;
  localparam logic [2:0] BACKGROUND_DEF  = 3'd0;

  // Launch line of a fresh shot: just above the ship.
  function automatic coord_t yStart(input int screenHeight, input int shipHeight,
                                    input int vOffset);
    return coord_t'((screenHeight - 1) - (shipHeight + vOffset));
  endfunction

endpackage

// File: rtl/laser_hit_test.sv
// Combinational shape test of one laser slot against the current pixel.
module laser_hit_test
  import laser_pkg::*;
#(
  parameter int RADIUS = 4
) (
  input  logic [9:0] h_pos,
  input  logic [9:0] v_pos,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic [1:0] mode,
  output logic       hit
);

  localparam logic [10:0] R_LIM  = 11'(RADIUS);
  localparam logic [10:0] R2_LIM = 11'(2 * RADIUS);
  localparam logic [21:0] R_SQ   = 22'(RADIUS * RADIUS);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [10:0]        adx;
  logic [10:0]        ady;
  logic [21:0]        adxWide;
  logic [21:0]        adyWide;
  logic [21:0]        sumSq;

  // Signed differences so a shot near the left edge still matches pixels left of it.
  assign dx = $signed({1'b0, h_pos}) - $signed({1'b0, x});
  assign dy = $signed({1'b0, v_pos}) - $signed({1'b0, y});
  assign adx = dx[10] ? -dx : dx;
  assign ady = dy[10] ? -dy : dy;
  assign adxWide = {11'd0, adx};
  assign adyWide = {11'd0, ady};
  assign sumSq   = adxWide * adxWide + adyWide * adyWide;

  // Select the shape test; inactive slots never hit.
  always_comb begin
    hit = 1'b0;
    if (active) begin
      if (mode == SQUARE) begin
        hit = (adx <= R_LIM) && (ady <= R_LIM);
      end else if (mode == BAR) begin
        hit = (adx <= 11'd1) && (ady <= R2_LIM);
      end else begin
        hit = (sumSq <= R_SQ);
      end
    end
  end

endmodule

// File: rtl/laser_bank.sv
// Multi-slot laser controller: allocation on fire press, upward motion,
// kill/top-of-screen release, and a registered pixel colour for the mixer.
module laser_bank
  import laser_pkg::*;
#(
  parameter int         NUM_SHOTS     = 4,
  parameter int         RADIUS        = 4,
  parameter int         SCREEN_HEIGHT = 480,
  parameter int         SHIP_HEIGHT   = 30,
  parameter int         V_OFFSET      = 10,
  parameter int         STEP_MOTION   = 1,
  parameter int         COOLDOWN      = 32,
  parameter logic [2:0] LASER_COLOR   = LASER_COLOR_DEF,
  parameter logic [2:0] BACKGROUND    = BACKGROUND_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    fire,
  input  logic [1:0]              mode,
  input  logic [9:0]              gun_x,
  input  logic [NUM_SHOTS-1:0]    kill,
  input  logic [9:0]              h_pos,
  input  logic [9:0]              v_pos,
  output logic [NUM_SHOTS-1:0]    shot_active,
  output logic [10*NUM_SHOTS-1:0] shot_x,
  output logic [10*NUM_SHOTS-1:0] shot_y,
  output logic                    fire_dropped,
  output logic [2:0]              color
);

  localparam coord_t Y_START = yStart(SCREEN_HEIGHT, SHIP_HEIGHT, V_OFFSET);
  localparam coord_t STEP    = coord_t'(STEP_MOTION);
  localparam int     CD_W    = 16;
  localparam int     IDX_W   = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;

  logic [NUM_SHOTS-1:0] activeReg;
  coord_t               xReg [NUM_SHOTS];
  coord_t               yReg [NUM_SHOTS];
  logic [CD_W-1:0]      cooldown;
  logic                 firePrev;
  logic                 dropReg;
  logic [2:0]           colorReg;

  logic                 fireEdge;
  logic                 accept;
  logic                 anyFree;
  logic [IDX_W-1:0]     allocIdx;
  logic [NUM_SHOTS-1:0] hitVec;

  assign fireEdge = fire & ~firePrev;
  assign accept   = fireEdge && (cooldown == '0) && anyFree;

  // Lowest-index free slot, judged on registered occupancy so a slot freed
  // this cycle is only reusable from the next one.
  always_comb begin
    anyFree  = 1'b0;
    allocIdx = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!activeReg[i]) begin
        anyFree  = 1'b1;
        allocIdx = IDX_W'(i);
      end
    end
  end

  // Edge detect, cooldown (loaded on accept, ticks down on enable) and drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      firePrev <= 1'b0;
      cooldown <= '0;
      dropReg  <= 1'b0;
    end else begin
      firePrev <= fire;
      dropReg  <= fireEdge && !accept;
      if (accept) begin
        cooldown <= CD_W'(COOLDOWN);
      end else if (enable && (cooldown != '0)) begin
        cooldown <= cooldown - CD_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_SHOTS; i++) begin : gSlot
    // Slot state: allocate, then kill beats motion; idle slots track the gun.
    always_ff @(posedge clk) begin
      if (reset) begin
        activeReg[i] <= 1'b0;
        xReg[i]      <= '0;
        yReg[i]      <= Y_START;
      end else if (accept && (allocIdx == IDX_W'(i))) begin
        activeReg[i] <= 1'b1;
        xReg[i]      <= gun_x;
        yReg[i]      <= Y_START;
      end else if (activeReg[i]) begin
        if (kill[i]) begin
          activeReg[i] <= 1'b0;
          yReg[i]      <= Y_START;
        end else if (enable) begin
          if (yReg[i] < STEP) begin
            activeReg[i] <= 1'b0;
            yReg[i]      <= Y_START;
          end else begin
            yReg[i] <= yReg[i] - STEP;
          end
        end
      end else begin
        xReg[i] <= gun_x;
        yReg[i] <= Y_START;
      end
    end

    laser_hit_test #(.RADIUS(RADIUS)) uHit (
      .h_pos (h_pos),
      .v_pos (v_pos),
      .x     (xReg[i]),
      .y     (yReg[i]),
      .active(activeReg[i]),
      .mode  (mode),
      .hit   (hitVec[i])
    );

    assign shot_x[10*i +: 10] = xReg[i];
    assign shot_y[10*i +: 10] = yReg[i];
  end

  // Registered pixel colour from the OR of all slot hits.
  always_ff @(posedge clk) begin
    if (reset) begin
      colorReg <= BACKGROUND;
    end else begin
      colorReg <= (|hitVec) ? LASER_COLOR : BACKGROUND;
    end
  end

  assign shot_active  = activeReg;
  assign fire_dropped = dropReg;
  assign color        = colorReg;

endmodule

// File: tb/tb_laser_bank.sv
// Directed bench for laser_bank: dutA uses the default cooldown of 32,
// dutB has no cooldown. Both share the same inputs.
module tb_laser_bank;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fire = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [9:0]    gunX = 10'd0;
  logic [NS-1:0] kill = '0;
  logic [9:0]    hPos = 10'd0;
  logic [9:0]    vPos = 10'd0;

  logic [NS-1:0]    activeA, activeB;
  logic [10*NS-1:0] xA, yA, xB, yB;
  logic             dropA, dropB;
  logic [2:0]       colorA, colorB;

  int total = 0;
  int bad   = 0;
  logic [2:0] expQ[$];

  typedef struct {
    logic [1:0] mode;
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] expColor;
  } vec_t;
  vec_t vecs[12];

  laser_bank #(.NUM_SHOTS(NS)) dutA (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .mode(mode),
    .gun_x(gunX), .kill(kill), .h_pos(hPos), .v_pos(vPos),
    .shot_active(activeA), .shot_x(xA), .shot_y(yA),
    .fire_dropped(dropA), .color(colorA)
  );

  laser_bank #(.NUM_SHOTS(NS), .COOLDOWN(0)) dutB (
    .clk(clk), .reset(reset), .enable(enable), .fire(fire), .mode(mode),
    .gun_x(gunX), .kill(kill), .h_pos(hPos), .v_pos(vPos),
    .shot_active(activeB), .shot_x(xB), .shot_y(yB),
    .fire_dropped(dropB), .color(colorB)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] slot(input logic [10*NS-1:0] v, input int i);
    return v[10*i +: 10];
  endfunction

  task automatic doReset();
    reset = 1'b1; fire = 1'b0; enable = 1'b0; kill = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // One press: fire high for a cycle (drop pulses sampled then), then low.
  task automatic press(output logic dA, output logic dB);
    fire = 1'b1;
    tick();
    dA = dropA;
    dB = dropB;
    fire = 1'b0;
    tick();
  endtask

  task automatic runEnable(input int n);
    enable = 1'b1;
    repeat (n) tick();
    enable = 1'b0;
  endtask

  initial begin
    logic dA, dB;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    check("rst_activeA", activeA, 0);
    check("rst_activeB", activeB, 0);
    check("rst_x0", slot(xB, 0), 0);
    check("rst_y0", slot(yB, 0), 439);
    check("rst_y3", slot(yA, 3), 439);
    check("rst_color", colorB, 0);
    check("rst_drop", dropA, 0);
    reset = 1'b0;

    // Single shot launch and motion
    gunX = 10'd320;
    press(dA, dB);
    check("fire1_drop", dA, 0);
    check("fire1_active", activeA, 4'b0001);
    check("fire1_x", slot(xA, 0), 320);
    check("fire1_y", slot(yA, 0), 439);
    runEnable(10);
    check("move10_y", slot(yA, 0), 429);
    check("move10_dropA", dropA, 0);

    // Cooldown on dutA
    doReset();
    press(dA, dB);
    runEnable(5);
    press(dA, dB);
    check("cd5_dropA", dA, 1);
    check("cd5_dropB", dB, 0);
    check("cd5_activeA", activeA, 4'b0001);
    runEnable(26);
    press(dA, dB);
    check("cd31_dropA", dA, 1);
    runEnable(1);
    press(dA, dB);
    check("cd32_dropA", dA, 0);
    check("cd32_activeA", activeA, 4'b0011);

    // Bank full and slot reuse on dutB
    doReset();
    for (int k = 0; k < NS; k++) begin
      press(dA, dB);
      check($sformatf("fill%0d_active", k), activeB, (1 << (k + 1)) - 1);
    end
    press(dA, dB);
    check("full_dropB", dB, 1);
    check("full_active", activeB, 4'b1111);
    kill = 4'b0100;
    tick();
    kill = '0;
    check("kill2_active", activeB, 4'b1011);
    check("kill2_y", slot(yB, 2), 439);
    gunX = 10'd77;
    press(dA, dB);
    check("reuse_active", activeB, 4'b1111);
    check("reuse_x2", slot(xB, 2), 77);
    check("reuse_y2", slot(yB, 2), 439);

    // Free at the top, and kill beating motion
    doReset();
    gunX = 10'd5;
    press(dA, dB);
    runEnable(439);
    check("top_y0", slot(yB, 0), 0);
    check("top_active", activeB, 4'b0001);
    runEnable(1);
    check("top_freed", activeB, 0);
    check("top_yreset", slot(yB, 0), 439);
    press(dA, dB);
    runEnable(239);
    check("y200", slot(yB, 0), 200);
    kill = 4'b0001;
    enable = 1'b1;
    tick();
    kill = '0;
    enable = 1'b0;
    check("killmove_active", activeB, 0);
    check("killmove_y", slot(yB, 0), 439);

    // Fire held high gives exactly one press
    doReset();
    fire = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold%0d_drop", k), dropB, 0);
    end
    fire = 1'b0;
    tick();
    check("hold_active", activeB, 4'b0001);

    // Rendering: inactive slot draws nothing
    doReset();
    gunX = 10'd100;
    mode = 2'd0; hPos = 10'd100; vPos = 10'd439;
    tick();
    check("inactive_color", colorB, 0);
    press(dA, dB);
    runEnable(239);
    check("render_x", slot(xB, 0), 100);
    check("render_y", slot(yB, 0), 200);

    // Rendering table, slot 0 at (100, 200), RADIUS 4
    vecs[0]  = '{2'd0, 10'd102, 10'd203, 3'd6};
    vecs[1]  = '{2'd0, 10'd103, 10'd203, 3'd0};
    vecs[2]  = '{2'd1, 10'd104, 10'd204, 3'd6};
    vecs[3]  = '{2'd1, 10'd105, 10'd204, 3'd0};
    vecs[4]  = '{2'd2, 10'd101, 10'd208, 3'd6};
    vecs[5]  = '{2'd2, 10'd102, 10'd200, 3'd0};
    vecs[6]  = '{2'd2, 10'd100, 10'd209, 3'd0};
    vecs[7]  = '{2'd3, 10'd100, 10'd204, 3'd6};
    vecs[8]  = '{2'd3, 10'd100, 10'd205, 3'd0};
    vecs[9]  = '{2'd0, 10'd96,  10'd200, 3'd6};
    vecs[10] = '{2'd1, 10'd96,  10'd196, 3'd6};
    vecs[11] = '{2'd0, 10'd400, 10'd300, 3'd0};
    for (int k = 0; k < 12; k++) begin
      mode = vecs[k].mode;
      hPos = vecs[k].h;
      vPos = vecs[k].v;
      expQ.push_back(vecs[k].expColor);
      tick();
      check($sformatf("render%0d", k), colorB, expQ.pop_front());
    end

    // Signed difference near the left edge
    doReset();
    gunX = 10'd2;
    press(dA, dB);
    mode = 2'd0; hPos = 10'd0; vPos = 10'd439;
    tick();
    check("edge_hit", colorB, 6);
    vPos = 10'd435;
    tick();
    check("edge_miss", colorB, 0);

    // Reset mid-flight beats a simultaneous fire edge
    doReset();
    gunX = 10'd50;
    press(dA, dB); press(dA, dB); press(dA, dB);
    check("mid_active", activeB, 4'b0111);
    runEnable(3);
    mode = 2'd0; hPos = 10'd50; vPos = 10'd436;
    tick();
    check("mid_color", colorB, 6);
    fire = 1'b1; enable = 1'b1; reset = 1'b1;
    tick();
    check("midrst_active", activeB, 0);
    check("midrst_color", colorB, 0);
    check("midrst_drop", dropB, 0);
    check("midrst_y0", slot(yB, 0), 439);
    check("midrst_x0", slot(xB, 0), 0);
    fire = 1'b0; enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_active", activeB, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
